// File: rtl/gsim_ax_check.sv
// Forward-model checker for the GSIM solver: recomputes b' = A*x for the fixed
// banded matrix (20, -13, 6, -1) from the streamed x vector, one result per accepted element.
module gsim_ax_check #(
  parameter int N = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] x_in,
  output logic        in_ready,
  output logic        out_valid,
  output logic [37:0] b_out,
  output logic        done,
  output logic        drop_err,
  output logic [1:0]  state_dbg
);

  // Handshake: an element transfers on a rising edge where in_valid and in_ready
  // are both high; in_valid while in_ready is low drops the element and sets drop_err.

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [1:0]      fcnt, fcnt_nx;
  logic [31:0]     win [7];
  logic [31:0]     sh [7];
  logic [31:0]     shift_in;
  logic            shift, clear_win, accept;
  logic            acc_vld, acc_vld_nx, acc_last, acc_last_nx;
  logic [37:0]     acc, sum;
  logic signed [37:0] e [7];

  function automatic logic signed [37:0] m20(input logic signed [37:0] v);
    return (v <<< 4) + (v <<< 2);
  endfunction

  function automatic logic signed [37:0] m13(input logic signed [37:0] v);
    return (v <<< 3) + (v <<< 2) + v;
  endfunction

  function automatic logic signed [37:0] m6(input logic signed [37:0] v);
    return (v <<< 2) + (v <<< 1);
  endfunction

  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    fcnt_nx     = fcnt;
    shift       = 1'b0;
    shift_in    = x_in;
    clear_win   = 1'b0;
    acc_vld_nx  = 1'b0;
    acc_last_nx = 1'b0;
    in_ready    = 1'b1;
    case (state)
      IDLE, RUN: begin
        if (accept) begin
          shift      = 1'b1;
          cnt_nx     = cnt + CW'(1);
          acc_vld_nx = (cnt >= CW'(3));
          if (cnt == CW'(N - 1)) begin
            state_nx = FLUSH;
            cnt_nx   = cnt;
            fcnt_nx  = 2'd0;
          end else if (cnt == CW'(3)) begin
            state_nx = RUN;
          end
        end
      end
      FLUSH: begin
        // Zeros stand in for x[N..N+2]; the last flush edge also rearms for a new frame.
        in_ready   = 1'b0;
        shift      = 1'b1;
        shift_in   = 32'd0;
        acc_vld_nx = 1'b1;
        fcnt_nx    = fcnt + 2'd1;
        if (fcnt == 2'd2) begin
          acc_last_nx = 1'b1;
          clear_win   = 1'b1;
          cnt_nx      = '0;
          fcnt_nx     = 2'd0;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The result is formed from the window as it looks after this edge's shift.
  always_comb begin
    for (int i = 0; i < 6; i++) sh[i] = win[i+1];
    sh[6] = shift_in;
    for (int i = 0; i < 7; i++) e[i] = {{6{sh[i][31]}}, sh[i]};
    sum = m20(e[3]) - m13(e[2]) - m13(e[4]) + m6(e[1]) + m6(e[5]) - e[0] - e[6];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      fcnt  <= 2'd0;
      for (int i = 0; i < 7; i++) win[i] <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      fcnt  <= fcnt_nx;
      for (int i = 0; i < 7; i++) begin
        if (clear_win)  win[i] <= 32'd0;
        else if (shift) win[i] <= sh[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      acc_vld   <= 1'b0;
      acc_last  <= 1'b0;
      b_out     <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      acc_vld  <= acc_vld_nx;
      acc_last <= acc_last_nx;
      if (acc_vld_nx) acc <= sum;
      out_valid <= acc_vld;
      done      <= acc_vld && acc_last;
      if (acc_vld) b_out <= acc;
      if (in_valid && !in_ready) drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gsim_ax_check.sv
// Bench for gsim_ax_check: fixed-pattern and random frames checked through an
// expected queue against the DUT's observed result stream.
module tb_gsim_ax_check;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] x_in = 32'd0;
  logic        in_ready, out_valid, done, drop_err;
  logic [37:0] b_out;
  logic [1:0]  state_dbg;

  logic [38:0] exp_q[$];
  logic [38:0] obs_q[$];
  logic [31:0] frame_x [N];
  int total = 0;
  int bad = 0;

  gsim_ax_check #(.N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in),
    .in_ready(in_ready), .out_valid(out_valid), .b_out(b_out),
    .done(done), .drop_err(drop_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && (out_valid || done)) obs_q.push_back({done && out_valid, out_valid ? b_out : 38'h3F_FFFF_FFFF});
  end

  function automatic logic [37:0] q16(input int v);
    longint t;
    t = longint'(v) * 64'sd65536;
    return t[37:0];
  endfunction

  function automatic logic [37:0] model(input int i);
    int c [7];
    longint s;
    c = '{-1, 6, -13, 20, -13, 6, -1};
    s = 0;
    for (int j = 0; j < 7; j++) begin
      int idx;
      idx = i + j - 3;
      if (idx >= 0 && idx < N) s += longint'(c[j]) * longint'($signed(frame_x[idx]));
    end
    return s[37:0];
  endfunction

  task automatic push_model();
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), model(i)});
  endtask

  task automatic drive_x(input logic [31:0] x);
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        in_valid = 1'b1;
        x_in = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      guard++;
      if (guard > 20) begin
        total++;
        bad++;
        $display("FAIL drive_timeout in_ready=%0b required=1", in_ready);
        return;
      end
    end
  endtask

  task automatic send_frame(input int max_gap, input int count);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      drive_x(frame_x[i]);
    end
  endtask

  task automatic check_outputs(input string name);
    int guard;
    logic [38:0] e, o;
    guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (6) @(negedge clk);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s_count got=%0d outputs required=%0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s_result got done=%0b b=%h required done=%0b b=%h", name, o[38], o[37:0], e[38], e[37:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if ({in_ready, out_valid, b_out, done, drop_err, state_dbg} !== {1'b1, 1'b0, 38'd0, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL %s got rdy=%0b vld=%0b b=%h done=%0b drop=%0b st=%0d required rdy=1 vld=0 b=0 done=0 drop=0 st=0",
               name, in_ready, out_valid, b_out, done, drop_err, state_dbg);
    end
  endtask

  task automatic push_ones();
    int t [N];
    t = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), q16(t[i])});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset_state");
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < N; i++) frame_x[i] = 32'h0001_0000;
    push_ones();
    send_frame(0, N);
    check_outputs("all_ones");
  endtask

  task automatic test_impulse();
    int t [N];
    for (int i = 0; i < N; i++) frame_x[i] = 32'd0;
    frame_x[0] = 32'h0001_0000;
    t = '{20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), q16(t[i])});
    send_frame(1, N);
    check_outputs("impulse");
  endtask

  task automatic test_neg_impulse();
    int t [N];
    for (int i = 0; i < N; i++) frame_x[i] = 32'd0;
    frame_x[7] = 32'hFFFF_0000;
    t = '{0, 0, 0, 0, 1, -6, 13, -20, 13, -6, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), q16(t[i])});
    send_frame(0, N);
    check_outputs("neg_impulse");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) frame_x[i] = $urandom();
    push_model();
    send_frame(2, N);
    for (int i = 0; i < N; i++) frame_x[i] = $urandom_range(0, 255) << 12;
    push_model();
    send_frame(2, N);
    check_outputs("back_to_back");
    total++;
    if (drop_err !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drop_err got=%0b required=0", drop_err);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < N; i++) frame_x[i] = $urandom();
    push_model();
    send_frame(0, N);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_in_ready got=%0b required=0", in_ready);
    end
    in_valid = 1'b1;
    x_in = 32'h1234_5678;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_outputs("drop_frame");
    total++;
    if (drop_err !== 1'b1) begin
      bad++;
      $display("FAIL drop_err got=%0b required=1", drop_err);
    end
    do_reset();
  endtask

  task automatic test_max();
    logic [37:0] peak;
    longint p;
    p = 64'sd60 * 64'sd2147483647;
    peak = p[37:0];
    for (int i = 0; i < N; i++) frame_x[i] = 32'd0;
    for (int i = 4; i <= 10; i++) frame_x[i] = (i % 2 == 1) ? 32'h7FFF_FFFF : 32'h8000_0001;
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), (i == 7) ? peak : model(i)});
    send_frame(1, N);
    check_outputs("max_magnitude");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) frame_x[i] = $urandom();
    send_frame(0, 9);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset_outputs");
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (obs_q.size() !== 0) begin
      bad++;
      $display("FAIL stale_after_reset got=%0d outputs required=0", obs_q.size());
    end
    obs_q.delete();
    for (int i = 0; i < N; i++) frame_x[i] = 32'h0001_0000;
    push_ones();
    send_frame(0, N);
    check_outputs("ones_after_reset");
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_impulse();
    test_neg_impulse();
    test_back_to_back();
    test_drop();
    test_max();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
